pipe_ctrl_unit: RTL and testbench
=================================

Name: pipe_ctrl_unit

Overview:
Next-generation control unit for the three-stage RV32I pipeline (F/D, X, W). It decodes the D-stage instruction and registers the control bundle into the X and W stages. It detects load-use and RAW hazards and generates stall, flush and bubble control, forwarding selects, memory-region tags and saturating stall/flush counters. It sits between the instruction register, the datapath muxes and the regfile/CSR write ports.

Parameters:
XLEN, 32, datapath/address width
CNT_W, 16, width of stall_cnt and flush_cnt (saturating)
TAG_DMEM_A, 4'h1, addr[XLEN-1:XLEN-4] tag mapped to DMEM
TAG_DMEM_B, 4'h3, second DMEM tag
TAG_BIOS, 4'h4, BIOS tag

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
instr_d  in  32  instruction in D stage
instr_valid_d  in  1  D holds a real instruction
should_br  in  1  X-stage branch compare result
alu_addr_x  in  XLEN  X-stage ALU result (load/store address)
stall_f  out  1  hold PC and D instruction register (combinational)
flush_d  out  1  squash D instruction (combinational)
x_valid  out  1  X holds a non-bubble instruction
x_alu_sel  out  4  {bit30 qualifier, funct3}
x_a_sel  out  1  1 = rs1, 0 = PC
x_b_sel  out  1  1 = rs2, 0 = imm
x_fwd_a  out  1  1 = operand A from W writeback value
x_fwd_b  out  1  1 = operand B from W writeback value
x_pc_sel  out  2  0 = boot, 2 = PC+4, 3 = ALU target (combinational from X)
x_csr_we  out  1  CSR write in X
x_csr_sel  out  1  1 = rs1 source, 0 = zimm
w_reg_we  out  1  regfile write enable
w_rd  out  5  destination register
w_wb_sel  out  2  0 = imm/none, 1 = PC+4, 2 = load, 3 = ALU
w_load_sel  out  3  load funct3
w_mem_region  out  2  0 = none, 1 = DMEM, 2 = BIOS
stall_cnt  out  CNT_W  stall cycles
flush_cnt  out  CNT_W  flush events
illegal_sticky  out  1  unknown opcode seen since reset

Behaviour:
- Reset (rst=0 at posedge): all X/W registers, counters and illegal_sticky are 0. x_pc_sel=0 and stall_f=flush_d=0 while rst=0. In-flight instructions are dropped, including a reset mid-stall.
- Decode per opcode:
  - ARI_R / ARI_I: ALU, wb 3. The I-type bit30 qualifier applies only to funct3=101.
  - LOAD: wb 2, load_sel=funct3.
  - STORE: no reg write.
  - LUI: wb 0.
  - AUIPC: a_sel=0, wb 3.
  - JAL / JALR: wb 1.
  - BRANCH: reg_we=0.
  - CSR: csr_we=1, csr_sel=~funct3[2], reg_we=0.
  - Unknown opcode: bubble, and sets illegal_sticky.
  - rd=x0 forces reg_we=0.
- Source usage: rs1 is used by R, I, LOAD, STORE, BRANCH, JALR and CSR with funct3[2]=0. rs2 is used by R, STORE and BRANCH.
- Pipeline advance, each posedge:
  - W <= X.
  - X <= decode(D), or a bubble if flush_d, stall_f or !instr_valid_d.
  - w_mem_region is computed from alu_addr_x tags when X is LOAD/STORE, else 0.
- Flush: flush_d = x_valid & (JAL | JALR | (BRANCH & should_br)). x_pc_sel=3 under the same condition, else 2. One-cycle penalty.
- Stall, load-use: stall_f = x_valid & X is LOAD & x_rd!=0 & (D uses rs1 & rs1==x_rd, or D uses rs2 & rs2==x_rd).
  - One cycle only: the next cycle X holds a bubble, so the condition clears.
  - The regfile provides write-first bypass for D reads.
- Flush has priority over stall: stall_f=0 whenever flush_d=1.
- Forwarding: x_fwd_a=1 when W reg_we & w_rd!=0 & w_rd==X rs1 & X uses rs1; x_fwd_b likewise for rs2. Registered at the D→X transfer.
- Counters: +1 per cycle with stall_f=1 (stall_cnt) and per cycle with flush_d=1 (flush_cnt). Both saturate at all-ones.

Optional Feature:
FWD_EN.
- Defined: forwarding as above; stall only on load-use.
- Undefined: x_fwd_a and x_fwd_b are tied to 0. stall_f asserts for any valid X producer with reg_we & rd!=0 matching a used D source, not just loads. Each such stall lasts 1 cycle.

Test Plan:
- rst=0 for 3 cycles with arbitrary instr_d → all outputs 0, x_pc_sel=0; release → x_pc_sel=2.
- LW x5,0(x1) then ADD x6,x5,x2 → stall_f=1 for exactly 1 cycle, X bubble, stall_cnt=1, ADD reaches W with w_rd=6, w_wb_sel=3.
- ADDI x3,x0,7 then SUB x4,x3,x3 (FWD_EN defined) → no stall, x_fwd_a=x_fwd_b=1 while SUB is in X. Without FWD_EN → 1 stall, fwd=0.
- BEQ in X with should_br=1 → flush_d=1, x_pc_sel=3, next X bubble, flush_cnt=1. With should_br=0 → no flush, x_pc_sel=2.
- LW with alu_addr_x=0x4000_0010 → w_mem_region=2. With 0x3000_0000 → 1. With 0x8000_0000 → 0.
- opcode 7'b1111111 → bubble (w_reg_we=0), illegal_sticky=1 until next reset; force stall_cnt to all-ones and stall → stays all-ones.

Source files
------------

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: RV32I 3-stage decode, hazard, flush and forwarding control.
// Define FWD_EN for W->X forwarding with load-use-only stalls; otherwise every RAW on X stalls.
module pipe_ctrl_unit #(
  parameter int XLEN = 32,
  parameter int CNT_W = 16,
  parameter logic [3:0] TAG_DMEM_A = 4'h1,
  parameter logic [3:0] TAG_DMEM_B = 4'h3,
  parameter logic [3:0] TAG_BIOS = 4'h4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr_d,
  input  logic             instr_valid_d,
  input  logic             should_br,
  input  logic [XLEN-1:0]  alu_addr_x,
  output logic             stall_f,
  output logic             flush_d,
  output logic             x_valid,
  output logic [3:0]       x_alu_sel,
  output logic             x_a_sel,
  output logic             x_b_sel,
  output logic             x_fwd_a,
  output logic             x_fwd_b,
  output logic [1:0]       x_pc_sel,
  output logic             x_csr_we,
  output logic             x_csr_sel,
  output logic             w_reg_we,
  output logic [4:0]       w_rd,
  output logic [1:0]       w_wb_sel,
  output logic [2:0]       w_load_sel,
  output logic [1:0]       w_mem_region,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             illegal_sticky
);
  typedef struct packed {
    logic       valid, ld, st, jmp, br;
    logic [3:0] alu_sel;
    logic       a_sel, b_sel, fwd_a, fwd_b, csr_we, csr_sel, reg_we;
    logic [4:0] rd;
    logic [1:0] wb_sel;
    logic [2:0] load_sel;
  } ctl_t;
  ctl_t d, x;
  logic [6:0] op;
  logic [2:0] f3;
  logic [4:0] rd, rs1, rs2;
  logic [3:0] tag;
  logic is_r, is_i, is_ld, is_st, is_lui, is_aui, is_jal, is_jalr, is_br, is_csr;
  logic legal, use1, use2, hit, hazard, adv;
  logic unused;
  assign op = instr_d[6:0];
  assign rd = instr_d[11:7];
  assign f3 = instr_d[14:12];
  assign rs1 = instr_d[19:15];
  assign rs2 = instr_d[24:20];
  assign tag = alu_addr_x[XLEN-1 -: 4];
  assign unused = ^{instr_d[31], instr_d[29:25], alu_addr_x[XLEN-5:0]};
  always_comb begin
    is_r = op == 7'b0110011;
    is_i = op == 7'b0010011;
    is_ld = op == 7'b0000011;
    is_st = op == 7'b0100011;
    is_lui = op == 7'b0110111;
    is_aui = op == 7'b0010111;
    is_jal = op == 7'b1101111;
    is_jalr = op == 7'b1100111;
    is_br = op == 7'b1100011;
    is_csr = op == 7'b1110011;
    legal = is_r | is_i | is_ld | is_st | is_lui | is_aui | is_jal | is_jalr | is_br | is_csr;
    use1 = is_r | is_i | is_ld | is_st | is_br | is_jalr | (is_csr & ~f3[2]);
    use2 = is_r | is_st | is_br;
    d = '0;
    d.valid = 1'b1;
    d.ld = is_ld;
    d.st = is_st;
    d.jmp = is_jal | is_jalr;
    d.br = is_br;
    d.alu_sel = is_r ? {instr_d[30], f3} : is_i ? {(f3 == 3'b101) & instr_d[30], f3} : 4'd0;
    // JAL and branches compute their target from PC in the ALU
    d.a_sel = ~(is_aui | is_jal | is_br);
    d.b_sel = is_r;
    d.csr_we = is_csr;
    d.csr_sel = is_csr & ~f3[2];
    d.reg_we = (is_r | is_i | is_ld | is_lui | is_aui | is_jal | is_jalr) & (rd != 5'd0);
    d.rd = rd;
    d.wb_sel = (is_r | is_i | is_aui) ? 2'd3 : is_ld ? 2'd2 : (is_jal | is_jalr) ? 2'd1 : 2'd0;
    d.load_sel = is_ld ? f3 : 3'd0;
`ifdef FWD_EN
    // X moves into W on the same edge D moves into X
    d.fwd_a = x.reg_we & (x.rd == rs1) & use1;
    d.fwd_b = x.reg_we & (x.rd == rs2) & use2;
`endif
  end
  assign hit = instr_valid_d & x.valid & x.reg_we & ((use1 & (rs1 == x.rd)) | (use2 & (rs2 == x.rd)));
`ifdef FWD_EN
  assign hazard = hit & x.ld;
`else
  assign hazard = hit;
`endif
  assign flush_d = rst & x.valid & (x.jmp | (x.br & should_br));
  assign stall_f = rst & ~flush_d & hazard;
  assign x_pc_sel = !rst ? 2'd0 : flush_d ? 2'd3 : 2'd2;
  assign adv = instr_valid_d & legal & ~flush_d & ~stall_f;
  assign x_valid = x.valid;
  assign x_alu_sel = x.alu_sel;
  assign x_a_sel = x.a_sel;
  assign x_b_sel = x.b_sel;
  assign x_fwd_a = x.fwd_a;
  assign x_fwd_b = x.fwd_b;
  assign x_csr_we = x.csr_we;
  assign x_csr_sel = x.csr_sel;
  always_ff @(posedge clk) begin
    if (!rst) begin
      x <= '0;
      w_reg_we <= 1'b0;
      w_rd <= 5'd0;
      w_wb_sel <= 2'd0;
      w_load_sel <= 3'd0;
      w_mem_region <= 2'd0;
      stall_cnt <= '0;
      flush_cnt <= '0;
      illegal_sticky <= 1'b0;
    end else begin
      x <= adv ? d : '0;
      w_reg_we <= x.reg_we;
      w_rd <= x.rd;
      w_wb_sel <= x.wb_sel;
      w_load_sel <= x.load_sel;
      w_mem_region <= !(x.ld | x.st) ? 2'd0 :
                      (tag == TAG_DMEM_A || tag == TAG_DMEM_B) ? 2'd1 :
                      (tag == TAG_BIOS) ? 2'd2 : 2'd0;
      if (stall_f && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_d && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
      if (instr_valid_d && !legal && !flush_d && !stall_f) illegal_sticky <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb_pipe_ctrl_unit: directed checks of pipe_ctrl_unit in either FWD_EN build.
module tb_pipe_ctrl_unit;
  localparam int CW = 4;
  localparam logic [31:0] LW5 = {12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011};
  localparam logic [31:0] ADD6 = {7'd0, 5'd2, 5'd5, 3'b000, 5'd6, 7'b0110011};
  localparam logic [31:0] ADDI3 = {12'd7, 5'd0, 3'b000, 5'd3, 7'b0010011};
  localparam logic [31:0] SUB4 = {7'b0100000, 5'd3, 5'd3, 3'b000, 5'd4, 7'b0110011};
  localparam logic [31:0] BEQ = {7'd0, 5'd0, 5'd0, 3'b000, 5'd0, 7'b1100011};
  localparam logic [31:0] JAL1 = {20'd0, 5'd1, 7'b1101111};
  localparam logic [31:0] ADD2 = {7'd0, 5'd1, 5'd1, 3'b000, 5'd2, 7'b0110011};
  localparam logic [31:0] LW7 = {12'd0, 5'd1, 3'b010, 5'd7, 7'b0000011};
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] ILL = 32'h0000_007f;
`ifdef FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0;
  logic [31:0] instr_d = '0, alu_addr_x = '0;
  logic instr_valid_d = 1'b0, should_br = 1'b0;
  logic stall_f, flush_d, x_valid, x_a_sel, x_b_sel, x_fwd_a, x_fwd_b, x_csr_we, x_csr_sel;
  logic w_reg_we, illegal_sticky;
  logic [3:0] x_alu_sel;
  logic [1:0] x_pc_sel, w_wb_sel, w_mem_region;
  logic [4:0] w_rd;
  logic [2:0] w_load_sel;
  logic [CW-1:0] stall_cnt, flush_cnt;
  int checks = 0, errors = 0, exp_stall = 0, exp_flush = 0;

  pipe_ctrl_unit #(.XLEN(32), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .instr_d(instr_d), .instr_valid_d(instr_valid_d),
    .should_br(should_br), .alu_addr_x(alu_addr_x), .stall_f(stall_f), .flush_d(flush_d),
    .x_valid(x_valid), .x_alu_sel(x_alu_sel), .x_a_sel(x_a_sel), .x_b_sel(x_b_sel),
    .x_fwd_a(x_fwd_a), .x_fwd_b(x_fwd_b), .x_pc_sel(x_pc_sel), .x_csr_we(x_csr_we),
    .x_csr_sel(x_csr_sel), .w_reg_we(w_reg_we), .w_rd(w_rd), .w_wb_sel(w_wb_sel),
    .w_load_sel(w_load_sel), .w_mem_region(w_mem_region), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt), .illegal_sticky(illegal_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic region(input logic [31:0] addr, input logic [1:0] exp);
    instr_d = LW7;
    step;
    instr_d = NOP;
    alu_addr_x = addr;
    step;
    #1 chk("mem_region", 32'(w_mem_region), 32'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    instr_d = LW5;
    instr_valid_d = 1'b1;
    should_br = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 chk("rst_pc_sel", 32'(x_pc_sel), 0);
    chk("rst_stall", 32'(stall_f), 0);
    chk("rst_flush", 32'(flush_d), 0);
    chk("rst_x_valid", 32'(x_valid), 0);
    chk("rst_w_we", 32'(w_reg_we), 0);
    chk("rst_cnt", 32'({stall_cnt, flush_cnt}), 0);
    chk("rst_illegal", 32'(illegal_sticky), 0);
    rst = 1'b1;
    instr_valid_d = 1'b0;
    should_br = 1'b0;
    #1 chk("run_pc_sel", 32'(x_pc_sel), 2);
    step;
    instr_valid_d = 1'b1;
    instr_d = LW5;
    step;
    instr_d = ADD6;
    alu_addr_x = 32'h4000_0010;
    #1 chk("lu_stall", 32'(stall_f), 1);
    exp_stall++;
    step;
    #1 chk("lu_stall_clear", 32'(stall_f), 0);
    chk("lu_bubble", 32'(x_valid), 0);
    chk("lu_stall_cnt", 32'(stall_cnt), 32'(exp_stall));
    chk("lw_region_bios", 32'(w_mem_region), 2);
    chk("lw_wb_sel", 32'(w_wb_sel), 2);
    chk("lw_load_sel", 32'(w_load_sel), 2);
    step;
    instr_d = NOP;
    #1 chk("add_x_valid", 32'(x_valid), 1);
    chk("add_fwd_a", 32'(x_fwd_a), 0);
    step;
    #1 chk("add_w_rd", 32'(w_rd), 6);
    chk("add_w_wb", 32'(w_wb_sel), 3);
    chk("add_w_we", 32'(w_reg_we), 1);
    instr_d = ADDI3;
    step;
    instr_d = SUB4;
    #1 chk("raw_stall", 32'(stall_f), 32'(!FWD));
    if (!FWD) begin
      exp_stall++;
      step;
      #1 chk("raw_bubble", 32'(x_valid), 0);
    end
    step;
    instr_d = NOP;
    #1 chk("sub_fwd_a", 32'(x_fwd_a), 32'(FWD));
    chk("sub_fwd_b", 32'(x_fwd_b), 32'(FWD));
    chk("sub_alu_sel", 32'(x_alu_sel), 8);
    chk("sub_b_sel", 32'(x_b_sel), 1);
    chk("raw_stall_cnt", 32'(stall_cnt), 32'(exp_stall));
    instr_d = BEQ;
    step;
    instr_d = NOP;
    should_br = 1'b1;
    #1 chk("br_flush", 32'(flush_d), 1);
    chk("br_pc_sel", 32'(x_pc_sel), 3);
    exp_flush++;
    step;
    should_br = 1'b0;
    #1 chk("br_bubble", 32'(x_valid), 0);
    chk("br_flush_cnt", 32'(flush_cnt), 32'(exp_flush));
    instr_d = BEQ;
    step;
    instr_d = NOP;
    #1 chk("nbr_flush", 32'(flush_d), 0);
    chk("nbr_pc_sel", 32'(x_pc_sel), 2);
    instr_d = JAL1;
    step;
    instr_d = ADD2;
    #1 chk("jal_flush", 32'(flush_d), 1);
    chk("jal_no_stall", 32'(stall_f), 0);
    exp_flush++;
    step;
    #1 chk("jal_flush_cnt", 32'(flush_cnt), 32'(exp_flush));
    region(32'h3000_0000, 2'd1);
    region(32'h8000_0000, 2'd0);
    instr_d = ILL;
    step;
    instr_d = NOP;
    #1 chk("ill_bubble", 32'(x_valid), 0);
    chk("ill_sticky", 32'(illegal_sticky), 1);
    step;
    #1 chk("ill_w_we", 32'(w_reg_we), 0);
    chk("ill_sticky_hold", 32'(illegal_sticky), 1);
    for (int i = 0; i < 16; i++) begin
      instr_d = LW5;
      step;
      instr_d = ADD6;
      #1 chk("sat_stall", 32'(stall_f), 1);
      if (exp_stall < 15) exp_stall++;
      step;
      step;
    end
    chk("sat_stall_cnt", 32'(stall_cnt), 32'(exp_stall));
    chk("sat_all_ones", 32'(stall_cnt), 15);
    rst = 1'b0;
    instr_d = NOP;
    step;
    #1 chk("rst2_illegal", 32'(illegal_sticky), 0);
    chk("rst2_cnt", 32'({stall_cnt, flush_cnt}), 0);
    chk("rst2_pc_sel", 32'(x_pc_sel), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
